// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle for the multicycle controller: status in, strobes/selects out.
// master = control FSM side, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic [OP_W-1:0]  opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             pc_src;
  logic [1:0]       ext_sel;
  logic [1:0]       rs_sel;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           ext_sel, rs_sel, halted, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           ext_sel, rs_sel, halted, instr_count
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 16-bit processor: FETCH/DECODE/EXEC/MEM/WB sequencer
// with memory-handshake stalls, illegal-opcode trap and a retired-fetch counter.
module mc_control_fsm #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB,
    EXEC_I, I_WB, BRANCH, JUMP, HALT
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic [1:0] ext_sel;
    logic [1:0] rs_sel;
    logic       halted;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctl, ctl_o;

  logic [3:0] op;
  logic       op_r, op_lw, op_sw, op_j, op_beq, op_ialu;
  logic [1:0] rs_dec, ext_dec;

  // zero only qualifies pc_write_cond inside the datapath
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign op = bus.opcode[3:0];

  always_comb begin
    op_r    = (op == 4'b0000);
    op_lw   = (op == 4'b0001);
    op_sw   = (op == 4'b0010);
    op_j    = (op == 4'b0011);
    op_beq  = (op == 4'b0100);
    op_ialu = (op inside {4'b1001, 4'b1101, 4'b0110, 4'b0111, 4'b1010, 4'b1110});

    rs_dec = 2'b10;
    if (op inside {4'b0000, 4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0110, 4'b0111, 4'b0011})
      rs_dec = 2'b00;
    else if (op_lw || op_sw)
      rs_dec = 2'b01;

    ext_dec = 2'b01;
    if (op inside {4'b1010, 4'b1110})
      ext_dec = 2'b00;
    else if (op_j)
      ext_dec = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctl         = '0;
    ctl.rs_sel  = rs_dec;
    ctl.ext_sel = ext_dec;
    case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        // speculative branch target: ALUOut <= PC + (sext8 << 1)
        ctl.alu_src_b = 2'b11;
        ctl.ext_sel   = 2'b01;
        if (op_lw || op_sw) state_d = MEM_ADDR;
        else if (op_r)      state_d = EXEC_R;
        else if (op_ialu)   state_d = EXEC_I;
        else if (op_beq)    state_d = BRANCH;
        else if (op_j)      state_d = JUMP;
        else                state_d = HALT;
      end
      MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b11;
        state_d       = op_lw ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      MEM_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_d       = FETCH;
      end
      EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = R_WB;
      end
      R_WB: begin
        ctl.reg_write = 1'b1;
        state_d       = FETCH;
      end
      EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = 2'b11;
        state_d       = I_WB;
      end
      I_WB: begin
        ctl.reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_src        = 1'b1;
        ctl.pc_write_cond = 1'b1;
        state_d           = FETCH;
      end
      JUMP: begin
        ctl.alu_src_b = 2'b11;
        ctl.ext_sel   = 2'b10;
        ctl.pc_write  = 1'b1;
        state_d       = FETCH;
      end
      HALT: begin
        ctl.halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // reset must silence the bus immediately, not just after the state register settles
  assign ctl_o = rst ? '0 : ctl;

  assign bus.pc_write      = ctl_o.pc_write;
  assign bus.pc_write_cond = ctl_o.pc_write_cond;
  assign bus.i_or_d        = ctl_o.i_or_d;
  assign bus.mem_read      = ctl_o.mem_read;
  assign bus.mem_write     = ctl_o.mem_write;
  assign bus.ir_write      = ctl_o.ir_write;
  assign bus.reg_dst       = ctl_o.reg_dst;
  assign bus.reg_write     = ctl_o.reg_write;
  assign bus.alu_src_a     = ctl_o.alu_src_a;
  assign bus.alu_src_b     = ctl_o.alu_src_b;
  assign bus.alu_op        = ctl_o.alu_op;
  assign bus.pc_src        = ctl_o.pc_src;
  assign bus.ext_sel       = ctl_o.ext_sel;
  assign bus.rs_sel        = ctl_o.rs_sel;
  assign bus.halted        = ctl_o.halted;
  assign bus.instr_count   = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: opcode table, multi-cycle corner sequences and a randomized
// run against a per-instruction step-list model.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();
  mc_control_fsm_if #(.CNT_W(4)) b4 ();

  mc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));
  mc_control_fsm #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       pcw, pwc, iord, mrd, mwr, irw, rdst, rwr, asa;
    logic [1:0] asb, aop;
    logic       psrc;
    logic [1:0] ext, rs;
    logic       hlt;
  } ov_t;

  typedef enum int {K_F, K_D, K_A, K_RD, K_LWB, K_WR, K_XR, K_RWB, K_XI, K_IWB, K_BR, K_J, K_H} kind_e;

  typedef struct {
    logic [3:0] op;
    logic [1:0] rs;
    logic [1:0] ext;
    int         lat;
    bit         halt;
  } vec_t;

  kind_e prog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ov_t dut_out();
    ov_t o;
    o = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
         bus.ir_write, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
         bus.alu_op, bus.pc_src, bus.ext_sel, bus.rs_sel, bus.halted};
    return o;
  endfunction

  function automatic logic [1:0] rs_ref(input logic [3:0] op);
    case (op)
      4'h0, 4'h9, 4'hA, 4'hD, 4'hE, 4'h6, 4'h7, 4'h3: return 2'b00;
      4'h1, 4'h2: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] ext_ref(input logic [3:0] op);
    case (op)
      4'hA, 4'hE: return 2'b00;
      4'h3: return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // expected bus contents for one step of an instruction
  function automatic ov_t exp_out(input kind_e k, input logic [3:0] op, input logic mr);
    ov_t o = '0;
    o.rs  = rs_ref(op);
    o.ext = ext_ref(op);
    case (k)
      K_F:   begin o.mrd = 1; o.asb = 2'b01; if (mr) begin o.irw = 1; o.pcw = 1; end end
      K_D:   begin o.asb = 2'b11; o.ext = 2'b01; end
      K_A:   begin o.asa = 1; o.asb = 2'b11; end
      K_RD:  begin o.mrd = 1; o.iord = 1; end
      K_WR:  begin o.mwr = 1; o.iord = 1; end
      K_LWB: begin o.rwr = 1; o.rdst = 1; end
      K_XR:  begin o.asa = 1; o.aop = 2'b10; end
      K_RWB, K_IWB: o.rwr = 1;
      K_XI:  begin o.asa = 1; o.asb = 2'b10; o.aop = 2'b11; end
      K_BR:  begin o.asa = 1; o.aop = 2'b01; o.psrc = 1; o.pwc = 1; end
      K_J:   begin o.asb = 2'b11; o.pcw = 1; o.ext = 2'b10; end
      K_H:   o.hlt = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic void plan(input logic [3:0] op);
    prog = {K_F, K_D};
    case (op)
      4'h0: begin prog.push_back(K_XR); prog.push_back(K_RWB); end
      4'h1: begin prog.push_back(K_A); prog.push_back(K_RD); prog.push_back(K_LWB); end
      4'h2: begin prog.push_back(K_A); prog.push_back(K_WR); end
      4'h3: prog.push_back(K_J);
      4'h4: prog.push_back(K_BR);
      4'h6, 4'h7, 4'h9, 4'hA, 4'hD, 4'hE: begin prog.push_back(K_XI); prog.push_back(K_IWB); end
      default: prog.push_back(K_H);
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] legal [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h9, 4'hA, 4'hD, 4'hE};
    logic [3:0] illeg [5]  = '{4'h5, 4'h8, 4'hB, 4'hC, 4'hF};
    if ($urandom_range(0, 15) == 0) return illeg[$urandom_range(0, 4)];
    return legal[$urandom_range(0, 10)];
  endfunction

  task automatic cyc(input logic mr, input logic z);
    @(negedge clk);
    bus.mem_ready = mr;
    bus.zero      = z;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b4.opcode    = 4'h3;
    b4.mem_ready = 1'b1;
    b4.zero      = 1'b0;
  end

  initial begin
    vec_t tbl[$];
    int n;
    logic mr;
    logic [3:0] rop;
    int idx, hcnt;
    logic [15:0] mcount;
    kind_e k;

    bus.opcode = 4'h0; bus.mem_ready = 1'b1; bus.zero = 1'b0;

    // reset state: everything quiet even though the state is FETCH
    #2;
    chk("rst_outs", dut_out(), '0);
    chk("rst_cnt", bus.instr_count, '0);
    @(negedge clk); #1;
    chk("rst_outs_edge", dut_out(), '0);

    // opcode table: decode selects and single-shot latency
    tbl = '{
      '{4'h0, 2'b00, 2'b01, 4, 0}, '{4'h1, 2'b01, 2'b01, 5, 0}, '{4'h2, 2'b01, 2'b01, 4, 0},
      '{4'h3, 2'b00, 2'b10, 3, 0}, '{4'h4, 2'b10, 2'b01, 3, 0}, '{4'h6, 2'b00, 2'b01, 4, 0},
      '{4'h7, 2'b00, 2'b01, 4, 0}, '{4'h9, 2'b00, 2'b01, 4, 0}, '{4'hD, 2'b00, 2'b01, 4, 0},
      '{4'hA, 2'b00, 2'b00, 4, 0}, '{4'hE, 2'b00, 2'b00, 4, 0}, '{4'hF, 2'b10, 2'b01, 0, 1},
      '{4'h5, 2'b10, 2'b01, 0, 1}, '{4'h8, 2'b10, 2'b01, 0, 1}
    };
    foreach (tbl[i]) begin
      do_reset();
      bus.opcode = tbl[i].op;
      cyc(1'b1, 1'b0);
      chk("tbl_ext_sel", bus.ext_sel, tbl[i].ext);
      cyc(1'b1, 1'b0);
      chk("tbl_rs_sel", bus.rs_sel, tbl[i].rs);
      chk("tbl_cnt", bus.instr_count, 16'd1);
      if (tbl[i].halt) begin
        cyc(1'b1, 1'b0);
        chk("tbl_halted", bus.halted, 1'b1);
      end else begin
        n = 2;
        do begin cyc(1'b1, 1'b0); n++; end while (!(bus.mem_read && !bus.i_or_d) && n < 20);
        chk("tbl_latency", n - 1, tbl[i].lat);
      end
    end

    // counter wrap on the narrow instance
    do_reset();
    n = 0;
    while (b4.instr_count != 4'hF && n < 100) begin @(negedge clk); n++; end
    chk("wrap_reach", b4.instr_count, 4'hF);
    n = 0;
    while (b4.instr_count == 4'hF && n < 10) begin @(negedge clk); n++; end
    chk("wrap_zero", b4.instr_count, 4'h0);

    // add: reg_write only in the 4th cycle
    do_reset();
    bus.opcode = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b1, 1'b0);
      chk("add_reg_write", bus.reg_write, c == 4);
    end
    chk("add_cnt", bus.instr_count, 16'd1);

    // lw with two wait cycles in MEM_RD
    do_reset();
    bus.opcode = 4'h1;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0); chk("lw_wait1", {bus.mem_read, bus.i_or_d}, 2'b11);
    cyc(1'b0, 1'b0); chk("lw_wait2", {bus.mem_read, bus.i_or_d}, 2'b11);
    cyc(1'b1, 1'b0); chk("lw_done", {bus.mem_read, bus.i_or_d}, 2'b11);
    chk("lw_rs_sel", bus.rs_sel, 2'b01);
    cyc(1'b1, 1'b0); chk("lw_wb", {bus.reg_write, bus.reg_dst}, 2'b11);
    cyc(1'b1, 1'b0); chk("lw_next_fetch", {bus.mem_read, bus.i_or_d}, 2'b10);

    // beq, taken and not taken look identical to the controller
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      bus.opcode = 4'h4;
      cyc(1'b1, 1'(z)); cyc(1'b1, 1'(z)); cyc(1'b1, 1'(z));
      chk("beq_branch", {bus.pc_write_cond, bus.pc_src, bus.alu_op, bus.pc_write}, 5'b11010);
      cyc(1'b1, 1'(z));
      chk("beq_next_fetch", {bus.mem_read, bus.i_or_d}, 2'b10);
    end

    // j
    do_reset();
    bus.opcode = 4'h3;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    chk("j_jump", {bus.ext_sel, bus.alu_src_b, bus.pc_write, bus.pc_src}, 6'b101110);
    cyc(1'b1, 1'b0);
    chk("j_next_fetch", {bus.mem_read, bus.i_or_d}, 2'b10);

    // illegal opcode traps until reset
    do_reset();
    bus.opcode = 4'hF;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      mr = 1'($urandom);
      cyc(mr, 1'b0);
      chk("halt_quiet", dut_out(), exp_out(K_H, 4'hF, mr));
    end
    @(negedge clk); rst = 1'b1; bus.mem_ready = 1'b0; #1;
    chk("halt_rst_halted", bus.halted, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk("halt_rst_fetch", {bus.mem_read, bus.i_or_d, bus.halted}, 3'b100);
    chk("halt_rst_cnt", bus.instr_count, 16'd0);

    // async reset in the middle of a store wait
    do_reset();
    bus.opcode = 4'h2;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0); chk("sw_wait", bus.mem_write, 1'b1);
    #1 rst = 1'b1;
    #1 chk("sw_rst_async", {bus.mem_write, bus.i_or_d}, 2'b00);
    @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b0; #1;
    chk("sw_rst_fetch", {bus.mem_read, bus.i_or_d, bus.mem_write}, 3'b100);

    // randomized instruction stream against the step-list model
    do_reset();
    mcount = '0; hcnt = 0; idx = 0;
    rop = rand_op(); plan(rop);
    repeat (400) begin
      @(negedge clk);
      mr = ($urandom_range(0, 2) != 0);
      bus.opcode = rop; bus.mem_ready = mr; bus.zero = 1'($urandom);
      #1;
      k = prog[idx];
      chk("rand_out", dut_out(), exp_out(k, rop, mr));
      chk("rand_cnt", bus.instr_count, mcount);
      if (k == K_H) begin
        hcnt++;
        if (hcnt == 3) begin
          do_reset();
          mcount = '0; hcnt = 0; idx = 0;
          rop = rand_op(); plan(rop);
        end
      end else if ((k == K_F || k == K_RD || k == K_WR) && !mr) begin
        hcnt = 0;
      end else begin
        if (k == K_F) mcount++;
        idx++;
        if (idx == prog.size()) begin
          idx = 0;
          rop = rand_op(); plan(rop);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
